// File: rtl/m92_gfx_pkg.sv
// Shared graphics constants, lane operation encoding and the bit-reverse helper
// used by the tile pixel shifter and its lanes.
package m92_gfx_pkg;

    localparam int PLANES_MIN   = 1;
    localparam int PLANES_MAX   = 8;
    localparam int WIDTH_NARROW = 8;
    localparam int WIDTH_WIDE   = 16;

    typedef enum logic [1:0] {
        LANE_HOLD  = 2'd0,
        LANE_SHIFT = 2'd1,
        LANE_LOAD  = 2'd2,
        LANE_CLEAR = 2'd3
    } lane_op_e;

    // Reverses the low w bits of v; the result sits in the low w bits, upper bits zero.
    function automatic logic [WIDTH_WIDE-1:0] bit_reverse(input logic [WIDTH_WIDE-1:0] v,
                                                          input int w);
        logic [WIDTH_WIDE-1:0] r;
        for (int i = 0; i < WIDTH_WIDE; i++) begin
            r[i] = v[WIDTH_WIDE-1-i];
        end
        return r >> (WIDTH_WIDE - w);
    endfunction

    function automatic logic legal_cfg(input int planes, input int width);
        return (planes >= PLANES_MIN) && (planes <= PLANES_MAX) &&
               ((width == WIDTH_NARROW) || (width == WIDTH_WIDE));
    endfunction

endpackage

// File: rtl/shift_lane.sv
// One bitplane lane: loads a word (optionally mirrored), shifts left one pixel at a
// time and presents its MSB as the current pixel bit.
module shift_lane
    import m92_gfx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  lane_op_e         op,
    input  logic             flip,
    input  logic [WIDTH-1:0] load_data,
    output logic             msb
);

    logic [WIDTH-1:0] lane_q;
    logic [WIDTH-1:0] lane_d;
    logic [WIDTH-1:0] load_rev;

    assign load_rev = WIDTH'(bit_reverse(WIDTH_WIDE'(load_data), WIDTH));

    always_comb begin
        lane_d = lane_q;
        case (op)
            LANE_SHIFT: lane_d = {lane_q[WIDTH-2:0], 1'b0};
            LANE_LOAD:  lane_d = flip ? load_rev : load_data;
            LANE_CLEAR: lane_d = '0;
            default:    lane_d = lane_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    assign msb = lane_q[WIDTH-1];

endmodule

// File: rtl/tile_pixel_shifter.sv
// Tile pixel shifter: one-word holding buffer feeding PLANES shift lanes, emitting
// one pixel per ce_pixel with seamless word-to-word reload.
module tile_pixel_shifter
    import m92_gfx_pkg::*;
#(
    parameter int PLANES = 4,
    parameter int WIDTH  = 8,
    parameter int PAL_W  = 7
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    ce_pixel,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PLANES*WIDTH-1:0] in_planes,
    input  logic                    in_flip,
    input  logic [PAL_W-1:0]        in_pal,
    output logic                    out_valid,
    output logic [PLANES-1:0]       out_color,
    output logic [PAL_W-1:0]        out_pal,
    output logic                    out_opaque,
    output logic                    underflow
);

    localparam int CW = $clog2(WIDTH + 1);

    if (!legal_cfg(PLANES, WIDTH)) begin : g_bad_cfg
        $error("tile_pixel_shifter: unsupported PLANES/WIDTH combination");
    end

    logic [PLANES*WIDTH-1:0] buf_planes_q, buf_planes_d;
    logic                    buf_flip_q,   buf_flip_d;
    logic [PAL_W-1:0]        buf_pal_q,    buf_pal_d;
    logic                    buf_full_q,   buf_full_d;
    logic [PAL_W-1:0]        pal_q,        pal_d;
    logic [CW-1:0]           cnt_q,        cnt_d;
    logic                    underflow_q,  underflow_d;
    lane_op_e                lane_op;
    logic [PLANES-1:0]       lane_msb;
    logic                    handshake;

    assign in_ready  = !buf_full_q;
    assign handshake = in_valid && in_ready && !flush;

    always_comb begin
        buf_planes_d = buf_planes_q;
        buf_flip_d   = buf_flip_q;
        buf_pal_d    = buf_pal_q;
        buf_full_d   = buf_full_q;
        pal_d        = pal_q;
        cnt_d        = cnt_q;
        underflow_d  = 1'b0;
        lane_op      = LANE_HOLD;

        if (flush) begin
            buf_full_d = 1'b0;
            cnt_d      = '0;
            lane_op    = LANE_CLEAR;
        end else begin
            if (ce_pixel) begin
                if (cnt_q > CW'(1)) begin
                    lane_op = LANE_SHIFT;
                    cnt_d   = cnt_q - CW'(1);
                end else if (buf_full_q) begin
                    lane_op    = LANE_LOAD;
                    pal_d      = buf_pal_q;
                    cnt_d      = CW'(WIDTH);
                    buf_full_d = 1'b0;
                end else begin
                    lane_op     = LANE_CLEAR;
                    cnt_d       = '0;
                    underflow_d = (cnt_q == CW'(1));
                end
            end
            // Capture after the drain decision so a same-cycle load uses the old contents.
            if (handshake) begin
                buf_planes_d = in_planes;
                buf_flip_d   = in_flip;
                buf_pal_d    = in_pal;
                buf_full_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_planes_q <= '0;
            buf_flip_q   <= 1'b0;
            buf_pal_q    <= '0;
            buf_full_q   <= 1'b0;
            pal_q        <= '0;
            cnt_q        <= '0;
            underflow_q  <= 1'b0;
        end else begin
            buf_planes_q <= buf_planes_d;
            buf_flip_q   <= buf_flip_d;
            buf_pal_q    <= buf_pal_d;
            buf_full_q   <= buf_full_d;
            pal_q        <= pal_d;
            cnt_q        <= cnt_d;
            underflow_q  <= underflow_d;
        end
    end

    for (genvar p = 0; p < PLANES; p++) begin : g_lane
        shift_lane #(.WIDTH(WIDTH)) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .op        (lane_op),
            .flip      (buf_flip_q),
            .load_data (buf_planes_q[p*WIDTH +: WIDTH]),
            .msb       (lane_msb[p])
        );
    end

    assign out_valid  = (cnt_q != '0);
    assign out_color  = lane_msb;
    assign out_pal    = pal_q;
    assign out_opaque = out_valid && (lane_msb != '0);
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_tile_pixel_shifter.sv
// Directed bench for tile_pixel_shifter: default and 16x6 configurations.
module tb_tile_pixel_shifter;

    logic clock;
    logic reset_n;

    logic        ce0, flush0, iv0, ir0, flip0, ov0, opq0, uf0;
    logic [31:0] planes0;
    logic [6:0]  pal0, opal0;
    logic [3:0]  col0;

    logic        ce1, flush1, iv1, ir1, flip1, ov1, opq1, uf1;
    logic [95:0] planes1;
    logic [6:0]  pal1, opal1;
    logic [5:0]  col1;

    int checks   = 0;
    int failures = 0;

    tile_pixel_shifter u_dut0 (
        .clock(clock), .reset_n(reset_n), .ce_pixel(ce0), .flush(flush0),
        .in_valid(iv0), .in_ready(ir0), .in_planes(planes0), .in_flip(flip0),
        .in_pal(pal0), .out_valid(ov0), .out_color(col0), .out_pal(opal0),
        .out_opaque(opq0), .underflow(uf0)
    );

    tile_pixel_shifter #(.PLANES(6), .WIDTH(16), .PAL_W(7)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .ce_pixel(ce1), .flush(flush1),
        .in_valid(iv1), .in_ready(ir1), .in_planes(planes1), .in_flip(flip1),
        .in_pal(pal1), .out_valid(ov1), .out_color(col1), .out_pal(opal1),
        .out_opaque(opq1), .underflow(uf1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic offer0(input logic [31:0] planes, input logic flip, input logic [6:0] pal);
        planes0 = planes;
        flip0   = flip;
        pal0    = pal;
        iv0     = 1'b1;
        tick();
        iv0     = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", ir0); end
        checks++; if (ov0 !== 1'b0 || col0 !== 4'h0 || opal0 !== 7'h0 || opq0 !== 1'b0 || uf0 !== 1'b0) begin
            failures++; $display("FAIL reset_out0 got v=%b c=%h p=%h o=%b u=%b exp zeros", ov0, col0, opal0, opq0, uf0);
        end
        checks++; if (ir1 !== 1'b1 || ov1 !== 1'b0 || col1 !== 6'h0 || uf1 !== 1'b0) begin
            failures++; $display("FAIL reset_out1 got r=%b v=%b c=%h u=%b exp r=1 zeros", ir1, ov1, col1, uf1);
        end
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_default();
        logic [3:0] exp;
        ce0 = 1'b0;
        offer0(32'h0000_0080, 1'b0, 7'h05);
        checks++; if (ir0 !== 1'b0 || ov0 !== 1'b0) begin
            failures++; $display("FAIL dflt_buffered got r=%b v=%b exp r=0 v=0", ir0, ov0);
        end
        ce0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = (i == 0) ? 4'h1 : 4'h0;
            checks++; if (ov0 !== 1'b1 || col0 !== exp || opal0 !== 7'h05 || uf0 !== 1'b0 || opq0 !== (exp != 4'h0)) begin
                failures++; $display("FAIL dflt_pixel%0d got v=%b c=%h p=%h u=%b o=%b exp v=1 c=%h p=05 u=0", i, ov0, col0, opal0, uf0, opq0, exp);
            end
        end
        tick();
        checks++; if (uf0 !== 1'b1 || ov0 !== 1'b0) begin
            failures++; $display("FAIL dflt_underflow got u=%b v=%b exp u=1 v=0", uf0, ov0);
        end
        tick();
        checks++; if (uf0 !== 1'b0) begin failures++; $display("FAIL dflt_uf_pulse got=%b exp=0", uf0); end
        ce0 = 1'b0;
    endtask

    task automatic test_flip();
        offer0(32'h0000_0001, 1'b1, 7'h55);
        ce0 = 1'b1;
        tick();
        checks++; if (col0 !== 4'h1 || opal0 !== 7'h55 || ov0 !== 1'b1) begin
            failures++; $display("FAIL flip_first got c=%h p=%h v=%b exp c=1 p=55 v=1", col0, opal0, ov0);
        end
        ce0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (col0 !== 4'h1 || ov0 !== 1'b1) begin
                failures++; $display("FAIL flip_hold%0d got c=%h v=%b exp c=1 v=1", i, col0, ov0);
            end
        end
        ce0 = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++; if (col0 !== 4'h0 || ov0 !== 1'b1) begin
                failures++; $display("FAIL flip_pixel%0d got c=%h v=%b exp c=0 v=1", i, col0, ov0);
            end
        end
        tick();
        checks++; if (uf0 !== 1'b1) begin failures++; $display("FAIL flip_underflow got=%b exp=1", uf0); end
        tick();
        ce0 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a_word;
        logic [3:0] exp_c;
        logic [6:0] exp_p;
        logic       pend;
        logic       hs_now;
        a_word = 8'hAA;
        offer0({24'h0, a_word}, 1'b0, 7'h11);
        ce0     = 1'b1;
        planes0 = 32'h0000_FF00;
        flip0   = 1'b0;
        pal0    = 7'h22;
        iv0     = 1'b1;
        pend    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            hs_now = pend && ir0;
            tick();
            if (hs_now) begin
                pend = 1'b0;
                iv0  = 1'b0;
            end
            if (i < 8) begin
                exp_c = {3'b000, a_word[7-i]};
                exp_p = 7'h11;
            end else begin
                exp_c = 4'b0010;
                exp_p = 7'h22;
            end
            checks++; if (ov0 !== 1'b1 || col0 !== exp_c || opal0 !== exp_p || uf0 !== 1'b0) begin
                failures++; $display("FAIL b2b_pixel%0d got v=%b c=%h p=%h u=%b exp v=1 c=%h p=%h u=0", i + 1, ov0, col0, opal0, uf0, exp_c, exp_p);
            end
        end
        iv0 = 1'b0;
        tick();
        checks++; if (uf0 !== 1'b1 || ov0 !== 1'b0) begin
            failures++; $display("FAIL b2b_end got u=%b v=%b exp u=1 v=0", uf0, ov0);
        end
        tick();
        ce0 = 1'b0;
    endtask

    task automatic test_flush();
        offer0(32'h0000_00FF, 1'b0, 7'h33);
        ce0 = 1'b1;
        tick();
        planes0 = 32'h0000_0F0F;
        pal0    = 7'h44;
        iv0     = 1'b1;
        tick();
        checks++; if (ir0 !== 1'b0) begin failures++; $display("FAIL flush_buffered got r=%b exp=0", ir0); end
        planes0 = 32'h0000_F0F0;
        tick();
        checks++; if (col0 !== 4'h1 || ov0 !== 1'b1 || opal0 !== 7'h33) begin
            failures++; $display("FAIL flush_pixel3 got c=%h v=%b p=%h exp c=1 v=1 p=33", col0, ov0, opal0);
        end
        flush0 = 1'b1;
        tick();
        checks++; if (ir0 !== 1'b1 || ov0 !== 1'b0 || uf0 !== 1'b0 || col0 !== 4'h0) begin
            failures++; $display("FAIL flush_clear got r=%b v=%b u=%b c=%h exp r=1 v=0 u=0 c=0", ir0, ov0, uf0, col0);
        end
        flush0 = 1'b0;
        iv0    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (ov0 !== 1'b0 || uf0 !== 1'b0 || ir0 !== 1'b1) begin
                failures++; $display("FAIL flush_dropped%0d got v=%b u=%b r=%b exp v=0 u=0 r=1", i, ov0, uf0, ir0);
            end
        end
        ce0 = 1'b0;
    endtask

    task automatic test_wide();
        ce1     = 1'b0;
        planes1 = '0;
        planes1[80 +: 16] = 16'hFFFF;
        flip1   = 1'b0;
        pal1    = 7'h7A;
        iv1     = 1'b1;
        tick();
        iv1 = 1'b0;
        checks++; if (ir1 !== 1'b0 || ov1 !== 1'b0) begin
            failures++; $display("FAIL wide_buffered got r=%b v=%b exp r=0 v=0", ir1, ov1);
        end
        ce1 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (ov1 !== 1'b1 || col1 !== 6'h20 || opq1 !== 1'b1 || opal1 !== 7'h7A || uf1 !== 1'b0) begin
                failures++; $display("FAIL wide_pixel%0d got v=%b c=%h o=%b p=%h u=%b exp v=1 c=20 o=1 p=7a u=0", i, ov1, col1, opq1, opal1, uf1);
            end
        end
        tick();
        checks++; if (uf1 !== 1'b1 || ov1 !== 1'b0 || opq1 !== 1'b0) begin
            failures++; $display("FAIL wide_end got u=%b v=%b o=%b exp u=1 v=0 o=0", uf1, ov1, opq1);
        end
        tick();
        ce1 = 1'b0;
    endtask

    task automatic test_async_reset();
        offer0(32'h0000_00FF, 1'b0, 7'h66);
        ce0 = 1'b1;
        tick();
        offer0(32'h0000_00FF, 1'b0, 7'h67);
        checks++; if (ov0 !== 1'b1 || ir0 !== 1'b0) begin
            failures++; $display("FAIL arst_pre got v=%b r=%b exp v=1 r=0", ov0, ir0);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (ov0 !== 1'b0 || col0 !== 4'h0 || opal0 !== 7'h0 || opq0 !== 1'b0 || ir0 !== 1'b1 || uf0 !== 1'b0) begin
            failures++; $display("FAIL arst_immediate got v=%b c=%h p=%h o=%b r=%b u=%b exp zeros r=1", ov0, col0, opal0, opq0, ir0, uf0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (ov0 !== 1'b0 || uf0 !== 1'b0) begin
                failures++; $display("FAIL arst_discard%0d got v=%b u=%b exp v=0 u=0", i, ov0, uf0);
            end
        end
        ce0 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        ce0 = 1'b0; flush0 = 1'b0; iv0 = 1'b0; planes0 = '0; flip0 = 1'b0; pal0 = '0;
        ce1 = 1'b0; flush1 = 1'b0; iv1 = 1'b0; planes1 = '0; flip1 = 1'b0; pal1 = '0;
        test_reset();
        test_default();
        test_flip();
        test_back_to_back();
        test_flush();
        test_wide();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
